countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: DVSR, default 10000000, prescaler modulus in clk cycles per 0.1 s tick (10 MHz-equivalent count at 100 MHz board clock; benches override).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  level; when 1, load ld_d3..ld_d0 into the digit registers.
REQ-005 go  input  1  level; 1 = count down, 0 = pause.
REQ-006 ld_d3, ld_d2, ld_d1, ld_d0  input  4 each  BCD preset: minutes, tens of seconds, seconds, tenths.
REQ-007 d3, d2, d1, d0  output  4 each  registered BCD remaining time M.SS.t.
REQ-008 done  output  1  registered; 1 while in EXPIRED.
REQ-009 running  output  1  registered; 1 while in RUN.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and EXPIRED.
REQ-011 Prescaler: 24-bit counter; counts 0..DVSR-1 only in RUN with go=1, then wraps to 0; holds its value otherwise.
REQ-012 tick SHALL be 1 when the FSM is in RUN, go=1 and prescaler==DVSR-1; the digits decrement on that same edge.
REQ-013 Decrement order: d0 9..0 with borrow to d1; d1 9..0 with borrow to d2; d2 5..0 with borrow to d3; d3 9..0.
REQ-014 A tick that brings the digits to 0.00.0 SHALL move the FSM to EXPIRED on the same edge and clear the prescaler.
REQ-015 IDLE: go=1 with non-zero digits -> RUN next edge; go=1 with digits 0.00.0 -> stay IDLE.
REQ-016 RUN: go=0 -> IDLE next edge; the prescaler keeps its partial count so a resume continues the same 0.1 s interval.
REQ-017 EXPIRED: go is ignored; the digits hold 0.00.0; only load or reset leaves this state.
REQ-018 load has priority over go and tick in every state: digits <- clamped preset, prescaler <- 0, FSM -> IDLE.
REQ-019 Clamping on load: ld_d0 and ld_d1 >9 -> 9; ld_d2 >5 -> 5; ld_d3 >9 -> 9.
REQ-020 Latency: the first decrement occurs DVSR cycles after entry to RUN when the prescaler is 0 (DVSR+1 edges after go is first sampled high in IDLE).
REQ-021 done and running SHALL be decoded from the registered state.

Reset
REQ-022 On reset=1: state IDLE; d3..d0 = 0; prescaler = 0; done = 0; running = 0.
REQ-023 Reset SHALL override load, go and tick in any state, including mid-RUN and mid-borrow.

Structure
REQ-024 Package countdown_pkg SHALL hold the state enum, the per-digit maxima (9, 9, 5, 9) and the DVSR default.
REQ-025 Sub-module bcd_digit_dn SHALL implement one digit with parameter MAX and ports load, load value, decrement enable, digit output and borrow-out; it is instantiated four times.

Verification (DVSR=4)
REQ-026 Reset -> d=0.00.0, done=0, running=0; go=1 with no load -> running stays 0.
REQ-027 Load 1.00.0, go=1 -> running=1 after 1 edge; 4 cycles later d=0.59.9.
REQ-028 Load 0.00.2, go held 1 -> d=0.00.1, then 0.00.0 with done=1 and running=0 on the same edge; further go leaves d unchanged.
REQ-029 Pause: in RUN with prescaler=2, go=0 for 10 cycles -> d unchanged and running=0; go=1 again -> decrement on the second edge after RUN is re-entered.
REQ-030 Load 0.30.0 while in RUN with go=1 -> next edge d=0.30.0, state IDLE, prescaler 0; following edge RUN.
REQ-031 Load ld_d2=7, ld_d0=12 (ld_d3=0, ld_d1=0) -> d=0.50.9; load while EXPIRED -> done=0 next edge.

Source files
------------

// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
//
// Shared definitions for the M.SS.t countdown timer:
//   - state_t      : controller states (idle, running, expired)
//   - D*_MAX       : largest value each BCD digit may hold
//   - DVSR_DEFAULT : prescaler modulus giving a 0.1 s tick from a 100 MHz clock
//   - PRESCALE_W   : width of the prescaler counter
//   - clampBcd     : saturates a preset nibble to a digit's maximum
// ---------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // Digit maxima, least significant first: tenths, seconds, tens of seconds,
  // minutes. The tens-of-seconds digit stops at 5 so the display reads M.SS.t.
  localparam int D0_MAX = 9;
  localparam int D1_MAX = 9;
  localparam int D2_MAX = 5;
  localparam int D3_MAX = 9;

  localparam int DVSR_DEFAULT = 10000000;
  localparam int PRESCALE_W   = 24;

  // Presets come straight from switches, so anything above a digit's maximum
  // is pulled down to that maximum instead of producing a non-BCD value.
  function automatic logic [3:0] clampBcd(input logic [3:0] value,
                                          input logic [3:0] maxValue);
    return (value > maxValue) ? maxValue : value;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// ---------------------------------------------------------------------------
// bcd_digit_dn
//
// One down-counting BCD digit that wraps from 0 to MAX.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset, clears the digit to 0
//   i_load     : load the clamped preset (wins over i_dec)
//   i_loadVal  : preset value, clamped to MAX on load
//   i_dec      : decrement enable for this cycle
//   o_digit    : registered digit value
//   o_borrow   : combinational; high when this digit decrements through 0,
//                used as the decrement enable of the next digit up
// ---------------------------------------------------------------------------
module bcd_digit_dn
  import countdown_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_loadVal,
  input  logic       i_dec,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] r_digit;

  // Borrow is combinational so a whole borrow ripple through all four digits
  // lands on the same edge as the tick that started it.
  assign o_borrow = i_dec && (r_digit == 4'd0);
  assign o_digit  = r_digit;

  // Digit register: reset, then load, then decrement with wrap to MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= clampBcd(i_loadVal, MAX_V);
    end else if (i_dec) begin
      r_digit <= (r_digit == 4'd0) ? MAX_V : (r_digit - 4'd1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Presettable M.SS.t countdown timer with a 0.1 s resolution.
//
// Ports:
//   clk                 : system clock, rising edge
//   reset               : synchronous active-high reset
//   load                : level; load ld_d3..ld_d0 (clamped) and go idle
//   go                  : level; 1 = count down, 0 = pause
//   ld_d3..ld_d0        : BCD preset (minutes, tens of s, seconds, tenths)
//   d3..d0              : registered BCD remaining time
//   done                : high while the timer has expired
//   running             : high while counting
//
// Parameter DVSR is the number of clk cycles per 0.1 s tick.
// ---------------------------------------------------------------------------
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int DVSR = DVSR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       go,
  input  logic [3:0] ld_d3,
  input  logic [3:0] ld_d2,
  input  logic [3:0] ld_d1,
  input  logic [3:0] ld_d0,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       done,
  output logic       running
);

  localparam logic [PRESCALE_W-1:0] LAST_COUNT = PRESCALE_W'(DVSR - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] w_nextPrescale;
  logic                  w_counting;
  logic                  w_tick;
  logic                  w_digitsZero;
  logic                  w_lastTenth;
  logic                  w_borrow0;
  logic                  w_borrow1;
  logic                  w_borrow2;
  logic                  w_unusedBorrow3;

  // The prescaler only advances while actively counting; the tick fires on
  // its final count so the digits step on the same edge it wraps.
  assign w_counting = (r_state == ST_RUN) && go;
  assign w_tick     = w_counting && (r_prescale == LAST_COUNT);

  assign w_digitsZero = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);

  // 0.00.1 is the only value one tick away from zero, so spotting it lets
  // the controller expire on the very edge the display reaches 0.00.0.
  assign w_lastTenth = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd1);

  // Digit chain, tenths first; each borrow is the next digit's decrement.
  bcd_digit_dn #(.MAX(D0_MAX)) u_digit0 (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_loadVal (ld_d0),
    .i_dec     (w_tick),
    .o_digit   (d0),
    .o_borrow  (w_borrow0)
  );

  bcd_digit_dn #(.MAX(D1_MAX)) u_digit1 (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_loadVal (ld_d1),
    .i_dec     (w_borrow0),
    .o_digit   (d1),
    .o_borrow  (w_borrow1)
  );

  bcd_digit_dn #(.MAX(D2_MAX)) u_digit2 (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_loadVal (ld_d2),
    .i_dec     (w_borrow1),
    .o_digit   (d2),
    .o_borrow  (w_borrow2)
  );

  // A borrow out of the minutes digit would need a tick at 0.00.0, which the
  // controller never issues, so it is left unused.
  bcd_digit_dn #(.MAX(D3_MAX)) u_digit3 (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_loadVal (ld_d3),
    .i_dec     (w_borrow2),
    .o_digit   (d3),
    .o_borrow  (w_unusedBorrow3)
  );

  // Next-state logic. Load is applied last so it overrides every transition.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (go && !w_digitsZero) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!go) begin
          w_nextState = ST_IDLE;
        end else if (w_tick && w_lastTenth) begin
          w_nextState = ST_EXPIRED;
        end
      end
      ST_EXPIRED: begin
        w_nextState = ST_EXPIRED;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    if (load) begin
      w_nextState = ST_IDLE;
    end
  end

  // Prescaler next value. Pausing holds the partial count so a resume
  // finishes the same 0.1 s interval; the wrap on the final count also
  // leaves it cleared when the timer expires.
  always_comb begin
    w_nextPrescale = r_prescale;
    if (load) begin
      w_nextPrescale = '0;
    end else if (w_counting) begin
      w_nextPrescale = (r_prescale == LAST_COUNT) ? '0 : (r_prescale + 1'b1);
    end
  end

  // State and prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
    end else begin
      r_state    <= w_nextState;
      r_prescale <= w_nextPrescale;
    end
  end

  // Status flags decode straight from the state register, so they change
  // only on clock edges.
  assign done    = (r_state == ST_EXPIRED);
  assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer with DVSR = 4. Every stimulus cycle
// runs a behavioural model that keeps the remaining time as a plain count of
// tenths; the expected display is pushed to a scoreboard queue and popped and
// compared just after the clock edge. Directed sequences are followed by a
// few hand-computed constant checks, then a random phase.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int DVSR = 4;

  typedef struct {
    logic [15:0] digits;
    logic        done;
    logic        running;
  } expect_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic       go;
  logic [3:0] ld_d3;
  logic [3:0] ld_d2;
  logic [3:0] ld_d1;
  logic [3:0] ld_d0;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       done;
  logic       running;

  expect_t sbQueue[$];

  int vectors     = 0;
  int miscompares = 0;

  // Model state: 0 idle, 1 run, 2 expired; time kept as total tenths.
  int mState  = 0;
  int mPre    = 0;
  int mTenths = 0;

  countdown_timer #(.DVSR(DVSR)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .go      (go),
    .ld_d3   (ld_d3),
    .ld_d2   (ld_d2),
    .ld_d1   (ld_d1),
    .ld_d0   (ld_d0),
    .d3      (d3),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .done    (done),
    .running (running)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check, reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int clampInt(input int value, input int maxValue);
    return (value > maxValue) ? maxValue : value;
  endfunction

  // Convert a tenths count back into packed BCD M.SS.t by arithmetic.
  function automatic logic [15:0] tenthsToBcd(input int tenths);
    int m;
    int rem;
    logic [15:0] bcd;
    m   = tenths / 600;
    rem = tenths % 600;
    bcd[15:12] = 4'(m);
    bcd[11:8]  = 4'(rem / 100);
    bcd[7:4]   = 4'((rem % 100) / 10);
    bcd[3:0]   = 4'(rem % 10);
    return bcd;
  endfunction

  // Advance the behavioural model by one clock edge.
  task automatic modelStep(input logic rst, input logic ld, input logic g,
                           input logic [3:0] l3, input logic [3:0] l2,
                           input logic [3:0] l1, input logic [3:0] l0);
    if (rst) begin
      mState  = 0;
      mPre    = 0;
      mTenths = 0;
    end else if (ld) begin
      mTenths = clampInt(int'(l3), 9) * 600 + clampInt(int'(l2), 5) * 100 +
                clampInt(int'(l1), 9) * 10 + clampInt(int'(l0), 9);
      mPre    = 0;
      mState  = 0;
    end else begin
      case (mState)
        0: if (g && mTenths != 0) mState = 1;
        1: begin
          if (!g) begin
            mState = 0;
          end else if (mPre == DVSR - 1) begin
            mPre    = 0;
            mTenths = mTenths - 1;
            if (mTenths == 0) mState = 2;
          end else begin
            mPre = mPre + 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one input pattern for n cycles; each cycle pushes the model's
  // expectation and compares the DUT against it 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic ld, input logic g,
                               input logic [3:0] l3, input logic [3:0] l2,
                               input logic [3:0] l1, input logic [3:0] l0,
                               input int n, input string tag);
    expect_t e;
    expect_t got;
    for (int i = 0; i < n; i++) begin
      reset = rst;
      load  = ld;
      go    = g;
      ld_d3 = l3;
      ld_d2 = l2;
      ld_d1 = l1;
      ld_d0 = l0;
      modelStep(rst, ld, g, l3, l2, l1, l0);
      e.digits  = tenthsToBcd(mTenths);
      e.done    = (mState == 2);
      e.running = (mState == 1);
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      if (sbQueue.size() == 0) begin
        checkOutput({tag, "_sbEmpty"}, 32'd0, 32'd1);
      end else begin
        got = sbQueue.pop_front();
        checkOutput({tag, "_digits"}, {16'd0, d3, d2, d1, d0}, {16'd0, got.digits});
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, got.done});
        checkOutput({tag, "_running"}, {31'd0, running}, {31'd0, got.running});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    go    = 1'b0;
    ld_d3 = 4'd0;
    ld_d2 = 4'd0;
    ld_d1 = 4'd0;
    ld_d0 = 4'd0;
    #2;

    // Reset state, then go with nothing loaded must not start the timer.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2, "reset");
    checkOutput("resetDigits", {16'd0, d3, d2, d1, d0}, 32'h0000);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 3, "goNoLoad");
    checkOutput("goNoLoadRunning", {31'd0, running}, 32'd0);

    // Load 1.00.0 and run: one edge to RUN, four more to the first tick.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, "load100");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "startRun");
    checkOutput("startRunRunning", {31'd0, running}, 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 3, "firstInterval");
    checkOutput("beforeTick", {16'd0, d3, d2, d1, d0}, 32'h1000);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "firstTick");
    checkOutput("firstTickBorrow", {16'd0, d3, d2, d1, d0}, 32'h0599);

    // Pause with the prescaler at 2, then resume.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 2, "toPrescale2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 10, "pause");
    checkOutput("pauseRunning", {31'd0, running}, 32'd0);
    checkOutput("pauseDigits", {16'd0, d3, d2, d1, d0}, 32'h0599);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "resume");
    checkOutput("resumeRunning", {31'd0, running}, 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "resume1");
    checkOutput("resumeNoTickYet", {16'd0, d3, d2, d1, d0}, 32'h0599);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "resume2");
    checkOutput("resumeTick", {16'd0, d3, d2, d1, d0}, 32'h0598);

    // Load while running with go held: load wins, then RUN restarts cleanly.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 2, "runMore");
    applyStimulus(0, 1, 1, 0, 3, 0, 0, 1, "loadInRun");
    checkOutput("loadInRunRunning", {31'd0, running}, 32'd0);
    checkOutput("loadInRunDigits", {16'd0, d3, d2, d1, d0}, 32'h0300);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, "reRun");
    checkOutput("reRunRunning", {31'd0, running}, 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 4, "reRunTick");
    checkOutput("reRunTickBorrow", {16'd0, d3, d2, d1, d0}, 32'h0299);

    // Run 0.00.2 down to expiry; go is then ignored.
    applyStimulus(0, 1, 1, 0, 0, 0, 2, 1, "load002");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 5, "toOne");
    checkOutput("atOne", {16'd0, d3, d2, d1, d0}, 32'h0001);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 4, "toZero");
    checkOutput("expiredDone", {31'd0, done}, 32'd1);
    checkOutput("expiredRunning", {31'd0, running}, 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 6, "expiredHold");
    checkOutput("expiredDigits", {16'd0, d3, d2, d1, d0}, 32'h0000);

    // Clamped load while expired clears done.
    applyStimulus(0, 1, 0, 0, 7, 0, 12, 1, "clampLoad");
    checkOutput("clampDigits", {16'd0, d3, d2, d1, d0}, 32'h0509);
    checkOutput("clampDone", {31'd0, done}, 32'd0);
    applyStimulus(0, 1, 0, 15, 15, 15, 15, 1, "clampAll");
    checkOutput("clampAllDigits", {16'd0, d3, d2, d1, d0}, 32'h9599);

    // Reset on the edge that would borrow 0.01.0 -> 0.00.9, with load and go.
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, "load010");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 4, "toBorrow");
    applyStimulus(1, 1, 1, 5, 5, 5, 5, 1, "resetMidBorrow");
    checkOutput("resetMidDigits", {16'd0, d3, d2, d1, d0}, 32'h0000);
    checkOutput("resetMidRunning", {31'd0, running}, 32'd0);

    // Random traffic, biased towards running with occasional loads.
    for (int i = 0; i < 400; i++) begin
      logic rr;
      logic rl;
      logic rg;
      rr = ($urandom_range(0, 99) == 0);
      rl = ($urandom_range(0, 19) == 0);
      rg = ($urandom_range(0, 3) != 0);
      applyStimulus(rr, rl, rg, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
